// File: rtl/game_ctrl_if.sv
// Controller <-> snake datapath bundle: button pulses and status in, move commands and FSM status out.
interface game_ctrl_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_pause;
  logic        game_over;
  logic [10:0] score;
  logic [2:0]  key_stroke;
  logic        step_en;
  logic        soft_rst;
  logic [2:0]  state;
  logic [2:0]  level;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right, btn_pause, game_over, score,
    output key_stroke, step_en, soft_rst, state, level
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, btn_pause, game_over, score,
    input  key_stroke, step_en, soft_rst, state, level
  );
endinterface

// File: rtl/game_ctrl.sv
// Snake game controller: run/pause/over/win FSM, direction filtering and level-scaled move ticks.
// step_en, soft_rst and key_stroke are registered, one cycle after the condition that causes them.
module game_ctrl #(
  parameter logic [10:0] WIN_SCORE = 11'd100,
  parameter logic [2:0]  MAX_LEVEL = 3'd4
) (
  input  logic        clk_5,
  input  logic        rst,
  game_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    RUN    = 3'b001,
    PAUSED = 3'b010,
    OVER   = 3'b011,
    WIN    = 3'b100
  } state_t;

  localparam logic [2:0] D_UP    = 3'b000;
  localparam logic [2:0] D_DOWN  = 3'b001;
  localparam logic [2:0] D_LEFT  = 3'b010;
  localparam logic [2:0] D_RIGHT = 3'b011;
  localparam logic [2:0] K_PAUSE = 3'b100;

  state_t     st;
  logic [2:0] cnt;
  logic [2:0] cur_dir;
  logic [2:0] nxt_dir;
  logic [2:0] key_q;
  logic       step_q;
  logic       soft_q;

  logic [7:0] score_div;
  logic [2:0] lvl;
  logic [2:0] thr;
  logic [2:0] press_dir;
  logic [2:0] step_dir;
  logic       press_any;
  logic       dir_ok;
  logic       win_hit;
  logic       step_hit;

  always_comb begin
    score_div = bus.score[10:3];
    lvl       = (score_div > {5'd0, MAX_LEVEL}) ? MAX_LEVEL : score_div[2:0];
    if (rst)
      lvl = 3'd0;
    // Period is 5-level, so a step fires once cnt reaches 4-level; using >= means
    // a level increase mid-count fires immediately rather than waiting for a wrap.
    thr       = 3'd4 - lvl;
    step_hit  = (cnt >= thr);
    win_hit   = (bus.score >= WIN_SCORE);
    press_any = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
    press_dir = bus.btn_up   ? D_UP   :
                bus.btn_down ? D_DOWN :
                bus.btn_left ? D_LEFT : D_RIGHT;
    // Opposites share bit 1 and differ in bit 0 (UP/DOWN, LEFT/RIGHT).
    dir_ok    = press_any &&
                !((press_dir[1] == cur_dir[1]) && (press_dir[0] != cur_dir[0]));
    step_dir  = dir_ok ? press_dir : nxt_dir;
  end

  always_ff @(posedge clk_5) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= 3'd0;
      cur_dir <= D_RIGHT;
      nxt_dir <= D_RIGHT;
      key_q   <= K_PAUSE;
      step_q  <= 1'b0;
      soft_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      soft_q <= 1'b0;
      key_q  <= K_PAUSE;
      case (st)
        IDLE: begin
          nxt_dir <= step_dir;
          if (press_any || bus.btn_pause) begin
            st  <= RUN;
            cnt <= 3'd0;
          end
        end
        RUN: begin
          nxt_dir <= step_dir;
          if (bus.game_over)
            st <= OVER;
          else if (win_hit)
            st <= WIN;
          else if (bus.btn_pause)
            st <= PAUSED;
          else if (step_hit) begin
            step_q  <= 1'b1;
            key_q   <= step_dir;
            cur_dir <= step_dir;
            cnt     <= 3'd0;
          end else
            cnt <= cnt + 3'd1;
        end
        PAUSED: begin
          if (bus.btn_pause) begin
            st  <= RUN;
            cnt <= 3'd0;
          end
        end
        OVER, WIN: begin
          if (bus.btn_pause) begin
            st      <= IDLE;
            soft_q  <= 1'b1;
            cur_dir <= D_RIGHT;
            nxt_dir <= D_RIGHT;
            cnt     <= 3'd0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.key_stroke = key_q;
  assign bus.step_en    = step_q;
  assign bus.soft_rst   = soft_q;
  assign bus.state      = st;
  assign bus.level      = lvl;
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: stimulus pushes expected move ticks into a scoreboard, a negedge monitor checks them.
module tb_game_ctrl;
  logic clk_5 = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  typedef struct {
    int         cyc;
    logic [2:0] key;
  } exp_t;
  exp_t sb[$];

  localparam logic [4:0] B_UP = 5'b10000;
  localparam logic [4:0] B_DN = 5'b01000;
  localparam logic [4:0] B_LT = 5'b00100;
  localparam logic [4:0] B_RT = 5'b00010;
  localparam logic [4:0] B_PS = 5'b00001;

  game_ctrl_if bus ();

  game_ctrl dut (
    .clk_5 (clk_5),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_5 = ~clk_5;
  always @(posedge clk_5) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step1();
    @(posedge clk_5);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step1();
  endtask

  // Press sampled on edge n; on return cyc == n and the edge's effects are visible.
  task automatic press_at(input int n, input logic [4:0] b);
    wait_to(n - 1);
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_pause} = b;
    step1();
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_pause} = 5'b0;
  endtask

  task automatic exp_step(input int c, input logic [2:0] k);
    exp_t e;
    e.cyc = c;
    e.key = k;
    sb.push_back(e);
  endtask

  always @(negedge clk_5) begin
    if (mon_on) begin
      if (bus.step_en === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_step", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("step_cycle", 32'(cyc), 32'(e.cyc));
          chk("step_key", 32'(bus.key_stroke), 32'(e.key));
        end
      end else begin
        chk("idle_key", 32'(bus.key_stroke), 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, q, r, s, t, u, v;
    rst = 1'b1;
    {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_pause} = 5'b0;
    bus.game_over = 1'b0;
    bus.score     = 11'd80;
    step1();
    mon_on = 1'b1;
    step1();
    step1();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_key", 32'(bus.key_stroke), 32'd4);
    chk("rst_step", 32'(bus.step_en), 32'd0);
    chk("rst_soft", 32'(bus.soft_rst), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_cnt", 32'(dut.cnt), 32'd0);
    chk("rst_cur_dir", 32'(dut.cur_dir), 32'd3);
    rst = 1'b0;
    bus.score = 11'd0;
    step1();
    step1();
    chk("idle_hold", 32'(bus.state), 32'd0);

    // Start and steady stepping, then direction filtering.
    p = cyc + 2;
    press_at(p, B_RT);
    chk("start_run", 32'(bus.state), 32'd1);
    exp_step(p + 5, 3'd3);
    exp_step(p + 10, 3'd3);
    exp_step(p + 15, 3'd3);
    exp_step(p + 20, 3'd3);
    press_at(p + 17, B_LT);
    press_at(p + 22, B_UP);
    exp_step(p + 25, 3'd0);
    press_at(p + 27, B_DN);
    exp_step(p + 30, 3'd0);
    press_at(p + 32, B_RT);
    exp_step(p + 35, 3'd3);
    press_at(p + 37, B_UP | B_LT);
    exp_step(p + 40, 3'd0);
    press_at(p + 41, B_LT);
    press_at(p + 42, B_RT);
    exp_step(p + 45, 3'd3);

    // Speed levels.
    q = p + 45;
    wait_to(q);
    bus.score = 11'd8;
    exp_step(q + 4, 3'd3);
    exp_step(q + 8, 3'd3);
    wait_to(q + 1);
    chk("level_8", 32'(bus.level), 32'd1);
    wait_to(q + 8);
    bus.score = 11'd32;
    for (int i = 9; i <= 12; i++) exp_step(q + i, 3'd3);
    wait_to(q + 9);
    chk("level_32", 32'(bus.level), 32'd4);
    wait_to(q + 12);
    bus.score = 11'd80;
    for (int i = 13; i <= 15; i++) exp_step(q + i, 3'd3);
    wait_to(q + 13);
    chk("level_80", 32'(bus.level), 32'd4);
    wait_to(q + 15);
    bus.score = 11'd0;
    exp_step(q + 20, 3'd3);
    wait_to(q + 16);
    chk("level_0", 32'(bus.level), 32'd0);
    wait_to(q + 23);
    bus.score = 11'd16;
    exp_step(q + 24, 3'd3);
    wait_to(q + 24);
    bus.score = 11'd0;
    exp_step(q + 29, 3'd3);

    // Pause: directions, game_over and win ignored while paused.
    r = q + 29;
    press_at(r + 1, B_PS);
    chk("paused", 32'(bus.state), 32'd2);
    press_at(r + 3, B_UP);
    wait_to(r + 5);
    bus.game_over = 1'b1;
    bus.score     = 11'd100;
    wait_to(r + 8);
    bus.game_over = 1'b0;
    bus.score     = 11'd0;
    chk("paused_hold", 32'(bus.state), 32'd2);
    press_at(r + 22, B_PS);
    chk("resume", 32'(bus.state), 32'd1);
    exp_step(r + 27, 3'd3);

    // Game over and restart.
    s = r + 27;
    press_at(s + 2, B_UP);
    exp_step(s + 5, 3'd0);
    wait_to(s + 5);
    bus.game_over = 1'b1;
    step1();
    chk("over", 32'(bus.state), 32'd3);
    press_at(s + 7, B_UP);
    chk("over_hold", 32'(bus.state), 32'd3);
    press_at(s + 9, B_PS);
    bus.game_over = 1'b0;
    chk("over_soft", 32'(bus.soft_rst), 32'd1);
    chk("over_idle", 32'(bus.state), 32'd0);
    chk("over_dir", 32'(dut.cur_dir), 32'd3);
    step1();
    chk("over_soft_pulse", 32'(bus.soft_rst), 32'd0);

    // Win, started by pause together with a direction.
    t = s + 11;
    press_at(t, B_UP | B_PS);
    chk("win_start", 32'(bus.state), 32'd1);
    exp_step(t + 5, 3'd0);
    wait_to(t + 5);
    bus.score = 11'd100;
    step1();
    chk("win", 32'(bus.state), 32'd4);
    press_at(t + 9, B_PS);
    chk("win_soft", 32'(bus.soft_rst), 32'd1);
    chk("win_idle", 32'(bus.state), 32'd0);
    chk("win_dir", 32'(dut.cur_dir), 32'd3);
    bus.score = 11'd0;

    // game_over outranks win.
    u = t + 11;
    press_at(u, B_RT);
    exp_step(u + 5, 3'd3);
    wait_to(u + 5);
    bus.score     = 11'd100;
    bus.game_over = 1'b1;
    step1();
    chk("prio_over", 32'(bus.state), 32'd3);
    bus.score     = 11'd0;
    bus.game_over = 1'b0;
    press_at(u + 8, B_PS);
    chk("prio_idle", 32'(bus.state), 32'd0);

    // Reset on the step cycle overrides everything.
    v = u + 10;
    press_at(v, B_RT);
    wait_to(v + 4);
    rst        = 1'b1;
    bus.score  = 11'd40;
    bus.btn_up = 1'b1;
    step1();
    chk("mid_rst_state", 32'(bus.state), 32'd0);
    chk("mid_rst_step", 32'(bus.step_en), 32'd0);
    chk("mid_rst_key", 32'(bus.key_stroke), 32'd4);
    chk("mid_rst_soft", 32'(bus.soft_rst), 32'd0);
    chk("mid_rst_level", 32'(bus.level), 32'd0);
    chk("mid_rst_nxt", 32'(dut.nxt_dir), 32'd3);
    bus.btn_up = 1'b0;
    rst        = 1'b0;
    bus.score  = 11'd0;
    for (int i = 0; i < 4; i++) step1();
    chk("post_rst_idle", 32'(bus.state), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 11'd100, score at which the game is won.
REQ-002 Parameter MAX_LEVEL, default 3'd4, highest speed level; SHALL be ≤4.
REQ-003 clk_5  input  1  game tick clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 btn_up, btn_down, btn_left, btn_right, btn_pause  input  1 each  pre-debounced, single-cycle press pulses.
REQ-006 game_over  input  1  high while the snake datapath is halted (its head direction is STOPPED).
REQ-007 score  input  11  current score from the snake datapath.
REQ-008 key_stroke  output  3  command to the snake datapath: UP=000, DOWN=001, LEFT=010, RIGHT=011, PAUSE=100.
REQ-009 step_en  output  1  one-cycle pulse marking a snake move tick.
REQ-010 soft_rst  output  1  one-cycle pulse that re-initialises the snake datapath.
REQ-011 state  output  3  FSM state: IDLE=000, RUN=001, PAUSED=010, OVER=011, WIN=100.
REQ-012 level  output  3  current speed level.

Function
REQ-013 FSM states SHALL be IDLE, RUN, PAUSED, OVER and WIN.
REQ-014 IDLE: any direction or pause press -> RUN, with the step counter cleared.
REQ-015 RUN: btn_pause -> PAUSED; game_over=1 -> OVER; score ≥ WIN_SCORE -> WIN. Priority: game_over > win > pause.
REQ-016 PAUSED: btn_pause -> RUN with the step counter cleared; direction presses SHALL be ignored; game_over/win SHALL NOT be evaluated.
REQ-017 OVER or WIN: btn_pause -> IDLE and soft_rst=1 for exactly that one cycle; all other inputs SHALL be ignored.
REQ-018 Direction register cur_dir SHALL reset to RIGHT, and SHALL also return to RIGHT on every soft_rst.
REQ-019 Pending register nxt_dir SHALL capture a direction press in IDLE or RUN.
  - Simultaneous presses: priority UP > DOWN > LEFT > RIGHT.
  - A press opposite cur_dir SHALL be discarded.
  - The last accepted press before a step wins.
REQ-020 Level SHALL equal min(score>>3, MAX_LEVEL), recomputed every cycle.
REQ-021 Step period SHALL be 5 − level cycles.
  - Counter cnt (3-bit) increments in RUN.
  - When cnt ≥ period−1: step_en=1 and cnt←0.
  - A level change mid-count SHALL take effect on the same comparison (≥), so no step is ever skipped indefinitely.
REQ-022 On a step_en cycle: key_stroke=nxt_dir and cur_dir←nxt_dir.
REQ-023 On every other cycle, and in every non-RUN state: key_stroke=PAUSE.
REQ-024 step_en SHALL be 0 outside RUN.
REQ-025 The cycle RUN exits SHALL NOT assert step_en.
REQ-026 Outputs step_en, soft_rst and key_stroke SHALL be registered: one cycle of latency from the qualifying condition.
REQ-027 btn_pause together with a direction press in IDLE SHALL start the game and also accept the direction.

Reset
REQ-028 While rst=1, regardless of the current state, outputs SHALL be: state=IDLE, key_stroke=PAUSE, step_en=0, soft_rst=0, level=0.
REQ-029 While rst=1, internal registers SHALL be: cnt=0, cur_dir=nxt_dir=RIGHT.
REQ-030 rst SHALL override every button and status input in the same cycle.
REQ-031 soft_rst SHALL NOT be asserted as a result of rst.

Verification
REQ-032 Start and step: reset, btn_right, score=0 -> state=RUN; step_en every 5 cycles; key_stroke=011 on those cycles and 100 otherwise.
REQ-033 Reversal reject: in RUN with cur_dir=RIGHT, press btn_left -> next step key_stroke=011; press btn_up -> next step key_stroke=000.
REQ-034 Speed-up: score driven 0 -> 8 -> 32 -> 80 -> step periods 5, 4, 1, 1; level=0, 1, 4, 4.
REQ-035 Pause: btn_pause in RUN -> state=PAUSED, no step_en for 20 cycles; btn_pause again -> RUN, first step_en 5 cycles later (score=0).
REQ-036 End and restart:
  - Drive game_over=1 in RUN -> state=OVER.
  - Then btn_pause -> soft_rst high for one cycle, state=IDLE, cur_dir=RIGHT.
  - Repeat with score=100 -> state=WIN.
REQ-037 Reset mid-operation: assert rst during RUN on a step cycle -> next cycle state=IDLE, step_en=0, key_stroke=100, soft_rst=0.
